// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar scan controller: clock-rate defaults,
// the FSM state encoding and the "no echo" distance code.
package sonar_pkg;

    // System clock rate the default timing constants are derived from
    localparam int CLK_HZ = 10_000_000;

    // Default block parameters
    localparam int DEF_STEPS         = 16;
    localparam int DEF_SETTLE_CYCLES = CLK_HZ / 5;    // 200 ms servo settle
    localparam int DEF_ACK_TIMEOUT   = 16;
    localparam int DEF_MEAS_TIMEOUT  = CLK_HZ / 25;   // 40 ms worst-case echo
    localparam int DEF_ABORT_CYCLES  = 4;
    localparam int DEF_MAX_RANGE     = 200;

    // Distance code for a missing echo or an aborted measurement
    localparam logic [7:0] NO_ECHO = 8'hFF;

    // State encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETTLE    = 3'd1;
    localparam logic [2:0] ST_TRIG      = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_CAPTURE   = 3'd5;
    localparam logic [2:0] ST_ABORT     = 3'd6;
    localparam logic [2:0] ST_STEP      = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_SETTLE    = ST_SETTLE,
        S_TRIG      = ST_TRIG,
        S_WAIT_ACK  = ST_WAIT_ACK,
        S_WAIT_DONE = ST_WAIT_DONE,
        S_CAPTURE   = ST_CAPTURE,
        S_ABORT     = ST_ABORT,
        S_STEP      = ST_STEP
    } state_t;

    // Largest of the four timer limits, used to size the shared timer
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sonar_cycle_timer.sv
// Up-counting cycle timer shared by every timed FSM state. A clear restarts
// the count at zero; the terminal-count flag rises once limit cycles have
// elapsed since the clear and the counter then holds so it cannot wrap.
module sonar_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count;

    // Count cycles since the last clear, saturating at terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!tc) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count >= (limit - W'(1)));

endmodule

// File: rtl/sonar_scan_ctrl.sv
// Sonar sweep scheduler: steps the servo index back and forth, waits for the
// mechanics to settle, fires one measurement per position through the sonar
// READY handshake (with ack / completion timeouts and an abort reset), and
// reports the nearest target found in each completed sweep.
module sonar_scan_ctrl
    import sonar_pkg::*;
#(
    parameter int  STEPS         = DEF_STEPS,
    parameter int  SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int  ACK_TIMEOUT   = DEF_ACK_TIMEOUT,
    parameter int  MEAS_TIMEOUT  = DEF_MEAS_TIMEOUT,
    parameter int  ABORT_CYCLES  = DEF_ABORT_CYCLES,
    parameter int  MAX_RANGE     = DEF_MAX_RANGE,
    localparam int IW            = $clog2(STEPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          sonar_ready,
    input  logic [7:0]    sonar_inches,
    output logic          do_measure,
    output logic          sonar_rst_n,
    output logic [IW-1:0] angle_idx,
    output logic          meas_valid,
    output logic [7:0]    meas_inches,
    output logic [IW-1:0] meas_idx,
    output logic          sweep_done,
    output logic [7:0]    target_inches,
    output logic [IW-1:0] target_idx,
    output logic          target_valid,
    output logic          busy
);

    localparam int            TMAX        = max_of4(SETTLE_CYCLES, ACK_TIMEOUT, MEAS_TIMEOUT, ABORT_CYCLES);
    localparam int            TW          = $clog2(TMAX) + 1;
    localparam logic [IW-1:0] LAST_IDX    = IW'(STEPS - 1);
    localparam logic [7:0]    RANGE_LIMIT = 8'(MAX_RANGE);

    state_t state;
    state_t next_state;

    // Shared timer controls
    logic          timer_clear;
    logic [TW-1:0] timer_limit;
    logic          timer_tc;

    // Next values of the registered handshake / status outputs
    logic          do_measure_d;
    logic          sonar_rst_n_d;
    logic          busy_d;
    logic          meas_load;
    logic [7:0]    meas_data;

    // Sweep bookkeeping
    logic          dir_up;
    logic [7:0]    run_min;
    logic [IW-1:0] run_min_idx;
    logic          sample_lt;
    logic [7:0]    cand_min;
    logic [IW-1:0] cand_idx;
    logic          sweep_end;

    sonar_cycle_timer #(
        .W (TW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .limit (timer_limit),
        .tc    (timer_tc)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic; handshake states always run to completion or abort
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (enable) next_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (timer_tc) next_state = S_TRIG;
            end
            S_TRIG: begin
                if (sonar_ready) next_state = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!sonar_ready)  next_state = S_WAIT_DONE;
                else if (timer_tc) next_state = S_ABORT;
            end
            S_WAIT_DONE: begin
                if (sonar_ready)   next_state = S_CAPTURE;
                else if (timer_tc) next_state = S_ABORT;
            end
            S_CAPTURE: begin
                next_state = S_STEP;
            end
            S_ABORT: begin
                if (timer_tc) next_state = S_STEP;
            end
            S_STEP: begin
                next_state = enable ? S_SETTLE : S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // FSM output logic: timer control plus next values of registered outputs
    always_comb begin
        timer_clear   = (next_state != state);
        timer_limit   = TW'(1);
        unique case (state)
            S_SETTLE:    timer_limit = TW'(SETTLE_CYCLES);
            S_WAIT_ACK:  timer_limit = TW'(ACK_TIMEOUT);
            S_WAIT_DONE: timer_limit = TW'(MEAS_TIMEOUT);
            S_ABORT:     timer_limit = TW'(ABORT_CYCLES);
            default:     timer_limit = TW'(1);
        endcase
        do_measure_d  = (state == S_TRIG) && sonar_ready;
        sonar_rst_n_d = (next_state != S_ABORT);
        busy_d        = (next_state != S_IDLE);
        meas_load     = (state == S_CAPTURE) || ((state == S_ABORT) && (next_state == S_STEP));
        meas_data     = (state == S_CAPTURE) ? sonar_inches : NO_ECHO;
    end

    // Register the handshake outputs and latch each completed sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            do_measure  <= 1'b0;
            sonar_rst_n <= 1'b1;
            busy        <= 1'b0;
            meas_valid  <= 1'b0;
            meas_inches <= NO_ECHO;
            meas_idx    <= '0;
        end else begin
            do_measure  <= do_measure_d;
            sonar_rst_n <= sonar_rst_n_d;
            busy        <= busy_d;
            meas_valid  <= meas_load;
            if (meas_load) begin
                meas_inches <= meas_data;
                meas_idx    <= angle_idx;
            end
        end
    end

    // Candidate running minimum including the latest sample; ties keep the older one
    always_comb begin
        sample_lt = (meas_inches < run_min);
        cand_min  = sample_lt ? meas_inches : run_min;
        cand_idx  = sample_lt ? meas_idx : run_min_idx;
        sweep_end = dir_up ? (angle_idx == LAST_IDX) : (angle_idx == '0);
    end

    // Advance the sweep in STEP: fold in the sample, publish at the endpoints
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle_idx     <= '0;
            dir_up        <= 1'b1;
            run_min       <= NO_ECHO;
            run_min_idx   <= '0;
            sweep_done    <= 1'b0;
            target_inches <= NO_ECHO;
            target_idx    <= '0;
            target_valid  <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (state == S_STEP) begin
                if (sweep_end) begin
                    target_inches <= cand_min;
                    target_idx    <= cand_idx;
                    target_valid  <= (cand_min < RANGE_LIMIT);
                    sweep_done    <= 1'b1;
                    run_min       <= NO_ECHO;
                    run_min_idx   <= '0;
                    dir_up        <= !dir_up;
                end else begin
                    run_min     <= cand_min;
                    run_min_idx <= cand_idx;
                    angle_idx   <= dir_up ? (angle_idx + IW'(1)) : (angle_idx - IW'(1));
                end
            end
        end
    end

endmodule

// File: tb/tb_sonar_scan_ctrl.sv
// Directed bench for sonar_scan_ctrl with a small behavioural sonar model.
module tb_sonar_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       sonar_ready;
    logic [7:0] sonar_inches;
    logic       do_measure;
    logic       sonar_rst_n;
    logic [1:0] angle_idx;
    logic       meas_valid;
    logic [7:0] meas_inches;
    logic [1:0] meas_idx;
    logic       sweep_done;
    logic [7:0] target_inches;
    logic [1:0] target_idx;
    logic       target_valid;
    logic       busy;

    int         assert_count;
    int         fail_count;

    // Model control: 0 = normal 3-cycle conversion, 1 = never acknowledges,
    // 2 = holds READY low for 60 cycles
    int         model_mode;
    int         m_idx;
    logic [7:0] echo_tab [4];

    sonar_scan_ctrl #(
        .STEPS         (4),
        .SETTLE_CYCLES (5),
        .ACK_TIMEOUT   (4),
        .MEAS_TIMEOUT  (50),
        .ABORT_CYCLES  (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .sonar_ready   (sonar_ready),
        .sonar_inches  (sonar_inches),
        .do_measure    (do_measure),
        .sonar_rst_n   (sonar_rst_n),
        .angle_idx     (angle_idx),
        .meas_valid    (meas_valid),
        .meas_inches   (meas_inches),
        .meas_idx      (meas_idx),
        .sweep_done    (sweep_done),
        .target_inches (target_inches),
        .target_idx    (target_idx),
        .target_valid  (target_valid),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic en, input logic rn);
        enable = en;
        rst_n  = rn;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assert_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic waitDoMeasure(input string tag);
        int n;
        n = 0;
        while (do_measure !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 16'(do_measure), 16'd1);
    endtask

    task automatic waitMeasValid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (meas_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 16'(meas_valid), 16'd1);
    endtask

    task automatic waitSweepDone(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (sweep_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 16'(sweep_done), 16'd1);
    endtask

    // Behavioural sonar: acknowledges a request by dropping READY, converts,
    // then presents the table distance for the requested index with READY
    initial begin
        sonar_ready  = 1'b1;
        sonar_inches = 8'd0;
        forever begin
            @(posedge clk);
            #2;
            if (do_measure === 1'b1 && model_mode != 1) begin
                m_idx        = int'(angle_idx);
                sonar_ready  = 1'b0;
                sonar_inches = 8'h00;
                if (model_mode == 2) begin
                    repeat (60) begin
                        @(posedge clk);
                        #2;
                    end
                end else begin
                    repeat (3) begin
                        @(posedge clk);
                        #2;
                    end
                end
                sonar_inches = echo_tab[m_idx];
                sonar_ready  = 1'b1;
            end
        end
    end

    initial begin
        int         n;
        int         cnt;
        logic [7:0] t1_exp [4];

        assert_count = 0;
        fail_count   = 0;
        model_mode   = 0;
        echo_tab     = '{8'd40, 8'd30, 8'd30, 8'd90};
        t1_exp       = '{8'd40, 8'd30, 8'd30, 8'd90};
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_do_measure",    16'(do_measure),    16'd0);
        checkOutput("rst_sonar_rst_n",   16'(sonar_rst_n),   16'd1);
        checkOutput("rst_angle_idx",     16'(angle_idx),     16'd0);
        checkOutput("rst_meas_valid",    16'(meas_valid),    16'd0);
        checkOutput("rst_meas_inches",   16'(meas_inches),   16'd255);
        checkOutput("rst_meas_idx",      16'(meas_idx),      16'd0);
        checkOutput("rst_sweep_done",    16'(sweep_done),    16'd0);
        checkOutput("rst_target_inches", 16'(target_inches), 16'd255);
        checkOutput("rst_target_idx",    16'(target_idx),    16'd0);
        checkOutput("rst_target_valid",  16'(target_valid),  16'd0);
        checkOutput("rst_busy",          16'(busy),          16'd0);

        $display("[TB] test 1: upward sweep 40,30,30,90");
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            waitMeasValid("t1_meas_valid");
            checkOutput("t1_meas_idx",    16'(meas_idx),    16'(i));
            checkOutput("t1_meas_inches", 16'(meas_inches), 16'(t1_exp[i]));
        end
        waitSweepDone("t1_sweep_done");
        checkOutput("t1_target_inches", 16'(target_inches), 16'd30);
        checkOutput("t1_target_idx",    16'(target_idx),    16'd1);
        checkOutput("t1_target_valid",  16'(target_valid),  16'd1);
        checkOutput("t1_angle_kept",    16'(angle_idx),     16'd3);

        $display("[TB] test 2: downward sweep, all 250");
        echo_tab = '{8'd250, 8'd250, 8'd250, 8'd250};
        for (int i = 0; i < 4; i++) begin
            waitMeasValid("t2_meas_valid");
            checkOutput("t2_meas_idx",    16'(meas_idx),    16'(3 - i));
            checkOutput("t2_meas_inches", 16'(meas_inches), 16'd250);
        end
        waitSweepDone("t2_sweep_done");
        checkOutput("t2_target_inches", 16'(target_inches), 16'd250);
        checkOutput("t2_target_idx",    16'(target_idx),    16'd3);
        checkOutput("t2_target_valid",  16'(target_valid),  16'd0);

        $display("[TB] test 3: no acknowledge");
        echo_tab   = '{8'd60, 8'd70, 8'd120, 8'd150};
        model_mode = 1;
        waitDoMeasure("t3_do_measure");
        checkOutput("t3_angle_idx", 16'(angle_idx), 16'd0);
        n = 0;
        while (sonar_rst_n === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t3_abort_latency", 16'(n), 16'd4);
        n = 0;
        while (sonar_rst_n === 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("t3_abort_length", 16'(n),           16'd3);
        checkOutput("t3_meas_valid",   16'(meas_valid),  16'd1);
        checkOutput("t3_meas_inches",  16'(meas_inches), 16'd255);
        checkOutput("t3_meas_idx",     16'(meas_idx),    16'd0);

        $display("[TB] test 4: conversion never finishes in time");
        model_mode = 2;
        waitDoMeasure("t4_do_measure");
        checkOutput("t4_angle_idx", 16'(angle_idx), 16'd1);
        n = 0;
        while (sonar_rst_n === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t4_abort_latency", 16'(n), 16'd51);
        n = 0;
        while (sonar_rst_n === 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("t4_abort_length", 16'(n),           16'd3);
        checkOutput("t4_meas_valid",   16'(meas_valid),  16'd1);
        checkOutput("t4_meas_inches",  16'(meas_inches), 16'd255);
        checkOutput("t4_meas_idx",     16'(meas_idx),    16'd1);
        model_mode = 0;
        cnt = 0;
        n   = 0;
        while (sonar_ready !== 1'b1 && n < 100) begin
            if (do_measure === 1'b1) cnt++;
            @(negedge clk);
            n++;
        end
        checkOutput("t4_no_trigger_while_busy", 16'(cnt),         16'd0);
        checkOutput("t4_ready_returned",        16'(sonar_ready), 16'd1);
        waitDoMeasure("t4_next_do_measure");
        checkOutput("t4_next_angle_idx", 16'(angle_idx), 16'd2);

        $display("[TB] test 5: enable dropped during conversion");
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        waitMeasValid("t5_meas_valid");
        checkOutput("t5_meas_idx",    16'(meas_idx),    16'd2);
        checkOutput("t5_meas_inches", 16'(meas_inches), 16'd120);
        @(negedge clk);
        checkOutput("t5_busy_idle",   16'(busy),      16'd0);
        checkOutput("t5_angle_step",  16'(angle_idx), 16'd3);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (do_measure !== 1'b0 || busy !== 1'b0) cnt++;
        end
        checkOutput("t5_quiet_while_idle", 16'(cnt), 16'd0);
        applyStimulus(1'b1, 1'b1);
        waitDoMeasure("t5_resume_do_measure");
        checkOutput("t5_resume_angle", 16'(angle_idx), 16'd3);
        waitMeasValid("t5_resume_meas_valid");
        checkOutput("t5_resume_meas_idx",    16'(meas_idx),    16'd3);
        checkOutput("t5_resume_meas_inches", 16'(meas_inches), 16'd150);
        waitSweepDone("t5_sweep_done");
        checkOutput("t5_target_inches", 16'(target_inches), 16'd120);
        checkOutput("t5_target_idx",    16'(target_idx),    16'd2);
        checkOutput("t5_target_valid",  16'(target_valid),  16'd1);

        $display("[TB] test 6: reset during conversion");
        model_mode = 2;
        waitDoMeasure("t6_do_measure");
        checkOutput("t6_angle_idx", 16'(angle_idx), 16'd3);
        repeat (10) @(negedge clk);
        #2;
        applyStimulus(1'b1, 1'b0);
        #1;
        checkOutput("t6_rst_do_measure",    16'(do_measure),    16'd0);
        checkOutput("t6_rst_sonar_rst_n",   16'(sonar_rst_n),   16'd1);
        checkOutput("t6_rst_busy",          16'(busy),          16'd0);
        checkOutput("t6_rst_angle_idx",     16'(angle_idx),     16'd0);
        checkOutput("t6_rst_meas_inches",   16'(meas_inches),   16'd255);
        checkOutput("t6_rst_meas_idx",      16'(meas_idx),      16'd0);
        checkOutput("t6_rst_target_inches", 16'(target_inches), 16'd255);
        checkOutput("t6_rst_target_idx",    16'(target_idx),    16'd0);
        checkOutput("t6_rst_target_valid",  16'(target_valid),  16'd0);
        @(negedge clk);
        @(negedge clk);
        model_mode = 0;
        applyStimulus(1'b1, 1'b1);
        cnt = 0;
        n   = 0;
        while (sonar_ready !== 1'b1 && n < 100) begin
            if (do_measure === 1'b1) cnt++;
            @(negedge clk);
            n++;
        end
        checkOutput("t6_no_trigger_while_busy", 16'(cnt),         16'd0);
        checkOutput("t6_ready_returned",        16'(sonar_ready), 16'd1);
        waitDoMeasure("t6_restart_do_measure");
        checkOutput("t6_restart_angle", 16'(angle_idx), 16'd0);
        waitMeasValid("t6_meas_valid0");
        checkOutput("t6_meas_idx0",    16'(meas_idx),    16'd0);
        checkOutput("t6_meas_inches0", 16'(meas_inches), 16'd60);
        waitMeasValid("t6_meas_valid1");
        checkOutput("t6_meas_idx1",    16'(meas_idx),    16'd1);
        checkOutput("t6_meas_inches1", 16'(meas_inches), 16'd70);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
